stream_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one valid/ready stream, typically the input of a backward-registered pipe stage, between N requesting valid/ready channels. Arbitration is packet-granular: a winner keeps the output until it transfers a beat flagged `last_f`. It then yields, and priority rotates to the next index. The block sits between the producer ports and the shared pipe stage, and reports the current owner and a completed-packet count.

---
 rtl/stream_rr_arbiter_pkg.sv | 21 ++
 rtl/stream_rr_arbiter_rr_pick.sv | 36 +++
 rtl/stream_rr_arbiter.sv | 103 ++++++++++
 tb/tb_stream_rr_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_rr_arbiter_pkg.sv
// Shared definitions for the round-robin stream arbiter: FSM encoding,
// index-width derivation and the slice convention for flattened buses.
package stream_defs;

  // Arbiter FSM: IDLE picks a winner, BUSY forwards the owner's packet.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Index width for N requesters; never narrower than one bit.
  function automatic int calc_iw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Channel ch of a flattened N*L bus occupies bits [ch*l +: l].
  function automatic int ch_lo(input int ch, input int l);
    return ch * l;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: the first set request bit at or above
// ptr, wrapping from N-1 back to 0. Rotate, priority-encode, un-rotate.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [N-1:0] rot;

  // Rotate so that ptr lands on bit 0, then take the lowest set bit.
  always_comb begin
    int s;
    int k;
    s   = 0;
    k   = 0;
    rot = '0;
    for (int j = 0; j < N; j++) begin
      s = j + int'(ptr);
      if (s >= N) s = s - N;
      rot[j] = req[s];
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) k = j;
    end
    s = k + int'(ptr);
    if (s >= N) s = s - N;
    idx = IW'(s);
    any = |req;
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one valid/ready stream
// between N producers. A winner keeps the stream until its last beat
// transfers; priority then rotates to the channel after it.
//
// Handshake: a beat moves on a port in any cycle where that port's valid
// and ready are both high. Ready on the producer side is the downstream
// ready routed to the owner only; valid/data/last are routed back from it.
module stream_rr_arbiter
  import stream_defs::*;
#(
  parameter int L  = 8,
  parameter int N  = 4,
  parameter int CW = 16,
  localparam int IW = calc_iw(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    valid_f,
  input  logic [N*L-1:0]  data_f,
  input  logic [N-1:0]    last_f,
  output logic [N-1:0]    ready_f,
  output logic            valid_b,
  output logic [L-1:0]    data_b,
  output logic            last_b,
  input  logic            ready_b,
  output logic [IW-1:0]   grant_id,
  output logic            busy,
  output logic [CW-1:0]   pkt_cnt
);

  state_e        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;

  logic          pick_any;
  logic [IW-1:0] pick_idx;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req (valid_f),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // State, owner, rotation pointer and packet counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // Next-state logic and the owner-routed stream muxes.
  always_comb begin
    logic hs_last;
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    valid_b   = 1'b0;
    data_b    = '0;
    last_b    = 1'b0;
    ready_f   = '0;
    hs_last   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        valid_b          = valid_f[owner_q];
        data_b           = data_f[ch_lo(int'(owner_q), L) +: L];
        last_b           = last_f[owner_q];
        ready_f[owner_q] = ready_b;
        hs_last          = valid_f[owner_q] & ready_b & last_f[owner_q];
        if (hs_last) begin
          state_d   = IDLE;
          ptr_d     = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);
          pkt_cnt_d = pkt_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_id = owner_q;
  assign busy     = (state_q == BUSY);
  assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter (N=4, L=8): a reset/mid-packet-reset
// sequence, a vector table for rotation and packet lock, hand-written
// backpressure and owner-stall sequences, then random traffic against a
// behavioural model. A second instance with CW=2 sees the same stimulus.
module tb_stream_rr_arbiter;

  localparam int N = 4;
  localparam int L = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   valid_f;
  logic [N*L-1:0] data_f;
  logic [N-1:0]   last_f;
  logic           ready_b;

  logic [N-1:0] ready_f, ready_f2;
  logic         valid_b, valid_b2;
  logic [L-1:0] data_b, data_b2;
  logic         last_b, last_b2;
  logic [1:0]   grant_id, grant_id2;
  logic         busy, busy2;
  logic [15:0]  pkt_cnt;
  logic [1:0]   pkt_cnt2;

  stream_rr_arbiter #(.L(L), .N(N), .CW(16)) dut (
    .clk(clk), .rst(rst), .valid_f(valid_f), .data_f(data_f),
    .last_f(last_f), .ready_f(ready_f), .valid_b(valid_b),
    .data_b(data_b), .last_b(last_b), .ready_b(ready_b),
    .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  stream_rr_arbiter #(.L(L), .N(N), .CW(2)) dut_cw2 (
    .clk(clk), .rst(rst), .valid_f(valid_f), .data_f(data_f),
    .last_f(last_f), .ready_f(ready_f2), .valid_b(valid_b2),
    .data_b(data_b2), .last_b(last_b2), .ready_b(ready_b),
    .grant_id(grant_id2), .busy(busy2), .pkt_cnt(pkt_cnt2)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Owner/pointer/count tracked as plain integers; winner found by a
  // linear scan from the pointer using modular arithmetic.
  bit m_busy;
  int m_owner, m_ptr, m_cnt;

  function automatic int pick_winner(input logic [N-1:0] vf, input int p);
    for (int off = 0; off < N; off++) begin
      if (vf[(p + off) % N]) return (p + off) % N;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_owner <= 0; m_ptr <= 0; m_cnt <= 0;
    end else if (!m_busy) begin
      if (valid_f != '0) begin
        m_owner <= pick_winner(valid_f, m_ptr);
        m_busy  <= 1'b1;
      end
    end else if (valid_f[m_owner] && ready_b && last_f[m_owner]) begin
      m_busy <= 1'b0;
      m_ptr  <= (m_owner + 1) % N;
      m_cnt  <= m_cnt + 1;
    end
  end

  task automatic check_model();
    logic [N-1:0] er;
    er = '0;
    if (m_busy) er[m_owner] = ready_b;
    chk("rnd_valid_b", 32'(valid_b), m_busy ? 32'(valid_f[m_owner]) : 32'd0);
    chk("rnd_data_b",  32'(data_b),  m_busy ? 32'(data_f[m_owner*L +: L]) : 32'd0);
    chk("rnd_last_b",  32'(last_b),  m_busy ? 32'(last_f[m_owner]) : 32'd0);
    chk("rnd_ready_f", 32'(ready_f), 32'(er));
    chk("rnd_busy",    32'(busy),    32'(m_busy));
    chk("rnd_grant",   32'(grant_id), 32'(m_owner));
    chk("rnd_pkt_cnt", 32'(pkt_cnt), 32'(m_cnt % 65536));
    chk("rnd_pkt_cnt_cw2", 32'(pkt_cnt2), 32'(m_cnt % 4));
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic r, input logic [3:0] vf, input logic [3:0] lf,
                       input logic [31:0] df, input logic rb);
    rst = r; valid_f = vf; last_f = lf; data_f = df; ready_b = rb;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [3:0]  vf;
    logic [3:0]  lf;
    logic [31:0] df;
    logic        rb;
    logic        e_valid;
    logic [7:0]  e_data;
    logic        e_last;
    logic [3:0]  e_ready;
    logic        e_busy;
    logic [1:0]  e_grant;
    int          e_cnt;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic r, input logic [3:0] vf, input logic [3:0] lf,
                              input logic [31:0] df, input logic rb, input logic ev,
                              input logic [7:0] ed, input logic el, input logic [3:0] er,
                              input logic eb, input logic [1:0] eg, input int ec);
    vec_t v;
    v.rst = r; v.vf = vf; v.lf = lf; v.df = df; v.rb = rb;
    v.e_valid = ev; v.e_data = ed; v.e_last = el; v.e_ready = er;
    v.e_busy = eb; v.e_grant = eg; v.e_cnt = ec;
    return v;
  endfunction

  localparam logic [31:0] D0 = 32'h1312_1110;

  initial begin
    // Reset with all requesting, then 1-beat packets from every channel:
    // grants 0,1,2,3,0 with an idle cycle between each.
    vecs[0]  = mk(0, 4'hF, 4'hF, D0, 1, 0, 8'h00, 0, 4'h0, 0, 0, 0);
    vecs[1]  = mk(1, 4'hF, 4'hF, D0, 1, 0, 8'h00, 0, 4'h0, 0, 0, 0);
    vecs[2]  = mk(1, 4'hF, 4'hF, D0, 1, 1, 8'h10, 1, 4'h1, 1, 0, 0);
    vecs[3]  = mk(1, 4'hF, 4'hF, D0, 1, 0, 8'h00, 0, 4'h0, 0, 0, 1);
    vecs[4]  = mk(1, 4'hF, 4'hF, D0, 1, 1, 8'h11, 1, 4'h2, 1, 1, 1);
    vecs[5]  = mk(1, 4'hF, 4'hF, D0, 1, 0, 8'h00, 0, 4'h0, 0, 1, 2);
    vecs[6]  = mk(1, 4'hF, 4'hF, D0, 1, 1, 8'h12, 1, 4'h4, 1, 2, 2);
    vecs[7]  = mk(1, 4'hF, 4'hF, D0, 1, 0, 8'h00, 0, 4'h0, 0, 2, 3);
    vecs[8]  = mk(1, 4'hF, 4'hF, D0, 1, 1, 8'h13, 1, 4'h8, 1, 3, 3);
    vecs[9]  = mk(1, 4'hF, 4'hF, D0, 1, 0, 8'h00, 0, 4'h0, 0, 3, 4);
    vecs[10] = mk(1, 4'hF, 4'hF, D0, 1, 1, 8'h10, 1, 4'h1, 1, 0, 4);
    vecs[11] = mk(1, 4'h0, 4'hF, D0, 1, 0, 8'h00, 0, 4'h0, 0, 0, 5);
    // ch1 single beat moves the pointer to 2.
    vecs[12] = mk(1, 4'h2, 4'h2, D0, 1, 0, 8'h00, 0, 4'h0, 0, 0, 5);
    vecs[13] = mk(1, 4'h2, 4'h2, D0, 1, 1, 8'h11, 1, 4'h2, 1, 1, 5);
    // Packet lock: ch2 sends A0,A1,A2 while ch0 keeps requesting.
    vecs[14] = mk(1, 4'h5, 4'h0, 32'h13A0_1110, 1, 0, 8'h00, 0, 4'h0, 0, 1, 6);
    vecs[15] = mk(1, 4'h5, 4'h0, 32'h13A0_1110, 1, 1, 8'hA0, 0, 4'h4, 1, 2, 6);
    vecs[16] = mk(1, 4'h5, 4'h0, 32'h13A1_1110, 1, 1, 8'hA1, 0, 4'h4, 1, 2, 6);
    vecs[17] = mk(1, 4'h5, 4'h4, 32'h13A2_1110, 1, 1, 8'hA2, 1, 4'h4, 1, 2, 6);
    // Pointer now 3; ch0 wins by wrapping the search.
    vecs[18] = mk(1, 4'h1, 4'h1, 32'h13A2_1120, 1, 0, 8'h00, 0, 4'h0, 0, 2, 7);
    vecs[19] = mk(1, 4'h1, 4'h1, 32'h13A2_1120, 1, 1, 8'h20, 1, 4'h1, 1, 0, 7);
    vecs[20] = mk(1, 4'h0, 4'h0, 32'h0000_0000, 1, 0, 8'h00, 0, 4'h0, 0, 0, 8);
  end

  // ---------------- test sequence ----------------
  initial begin
    apply(0, 4'h0, 4'h0, 32'h0, 1'b0);
    repeat (3) next_cycle();
    #3;
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_pkt_cnt", 32'(pkt_cnt), 32'd0);

    // Reset during beat 2 of a 4-beat ch1 packet.
    apply(1, 4'h2, 4'h0, 32'h0000_4000, 1);
    #3 chk("rmp_idle", 32'(busy), 32'd0);
    next_cycle();
    apply(1, 4'h2, 4'h0, 32'h0000_4000, 1);
    #3 chk("rmp_beat1_valid", 32'(valid_b), 32'd1);
    chk("rmp_beat1_data", 32'(data_b), 32'h40);
    chk("rmp_beat1_grant", 32'(grant_id), 32'd1);
    next_cycle();
    apply(1, 4'h2, 4'h0, 32'h0000_4100, 1);
    #3 chk("rmp_beat2_data", 32'(data_b), 32'h41);
    rst = 1'b0;
    #1;
    chk("rmp_rst_busy", 32'(busy), 32'd0);
    chk("rmp_rst_valid_b", 32'(valid_b), 32'd0);
    chk("rmp_rst_ready_f", 32'(ready_f), 32'd0);
    chk("rmp_rst_grant", 32'(grant_id), 32'd0);
    chk("rmp_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    next_cycle();

    // Table-driven vectors.
    for (int i = 0; i < 21; i++) begin
      apply(vecs[i].rst, vecs[i].vf, vecs[i].lf, vecs[i].df, vecs[i].rb);
      #3;
      chk($sformatf("vec%0d_valid_b", i), 32'(valid_b), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_data_b", i), 32'(data_b), 32'(vecs[i].e_data));
      chk($sformatf("vec%0d_last_b", i), 32'(last_b), 32'(vecs[i].e_last));
      chk($sformatf("vec%0d_ready_f", i), 32'(ready_f), 32'(vecs[i].e_ready));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d_grant", i), 32'(grant_id), 32'(vecs[i].e_grant));
      chk($sformatf("vec%0d_pkt_cnt", i), 32'(pkt_cnt), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_pkt_cnt_cw2", i), 32'(pkt_cnt2), 32'(vecs[i].e_cnt % 4));
      next_cycle();
    end

    // Backpressure: ch1 beat 0x5A held for 4 cycles with ready_b low.
    apply(1, 4'h2, 4'h2, 32'h0000_5A00, 0);
    #3 chk("bp_idle", 32'(busy), 32'd0);
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      #3;
      chk("bp_hold_valid_b", 32'(valid_b), 32'd1);
      chk("bp_hold_data_b", 32'(data_b), 32'h5A);
      chk("bp_hold_ready_f", 32'(ready_f), 32'h0);
      chk("bp_hold_grant", 32'(grant_id), 32'd1);
      next_cycle();
    end
    ready_b = 1'b1;
    #3 chk("bp_go_ready_f", 32'(ready_f), 32'h2);
    chk("bp_go_valid_b", 32'(valid_b), 32'd1);
    next_cycle();
    apply(1, 4'h0, 4'h0, 32'h0, 1);
    #3 chk("bp_done_busy", 32'(busy), 32'd0);
    chk("bp_done_pkt_cnt", 32'(pkt_cnt), 32'd9);
    next_cycle();

    // Owner stall: ch3 drops valid for 2 cycles while ch0 requests.
    apply(1, 4'h8, 4'h0, 32'h3000_0000, 1);
    #3 chk("st_idle", 32'(busy), 32'd0);
    next_cycle();
    #3 chk("st_beat_valid_b", 32'(valid_b), 32'd1);
    chk("st_beat_grant", 32'(grant_id), 32'd3);
    chk("st_beat_data", 32'(data_b), 32'h30);
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      apply(1, 4'h1, 4'h1, 32'h3000_0022, 1);
      #3;
      chk("st_stall_valid_b", 32'(valid_b), 32'd0);
      chk("st_stall_ready_f", 32'(ready_f), 32'h8);
      chk("st_stall_busy", 32'(busy), 32'd1);
      chk("st_stall_grant", 32'(grant_id), 32'd3);
      next_cycle();
    end
    apply(1, 4'h9, 4'h8, 32'h3100_0022, 1);
    #3 chk("st_last_valid_b", 32'(valid_b), 32'd1);
    chk("st_last_last_b", 32'(last_b), 32'd1);
    chk("st_last_data", 32'(data_b), 32'h31);
    next_cycle();
    apply(1, 4'h3, 4'h3, 32'h0000_2322, 1);
    #3 chk("st_wrap_idle", 32'(busy), 32'd0);
    chk("st_wrap_pkt_cnt", 32'(pkt_cnt), 32'd10);
    next_cycle();
    #3 chk("st_wrap_grant", 32'(grant_id), 32'd0);
    chk("st_wrap_data", 32'(data_b), 32'h22);
    next_cycle();
    apply(1, 4'h0, 4'h0, 32'h0, 1);
    #3 chk("st_end_pkt_cnt", 32'(pkt_cnt), 32'd11);
    chk("st_end_pkt_cnt_cw2", 32'(pkt_cnt2), 32'd3);
    next_cycle();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      logic [3:0] vf, lf;
      vf = 4'($urandom_range(0, 15));
      lf = '0;
      for (int k = 0; k < N; k++) lf[k] = ($urandom_range(0, 2) == 0);
      apply(1, vf, lf, $urandom, ($urandom_range(0, 3) != 0));
      #3 check_model();
      next_cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
